sol_line_arbiter: RTL and testbench
===================================

# sol_line_arbiter

Line-granular round-robin arbiter that shares one puzzle-solver core between two independent byte-stream requesters. It sits directly in front of the solver's `char_in`/`input_valid` port and locks onto one requester for a whole input line, so each solver line parse sees contiguous bytes. Lock release happens on a newline or on the requester's last byte. The block also tracks end-of-stream for both sources and flags completion once every line has been handed to the solver.

## Interface
Parameters:
- `LINE_TERM`, default 8'd10: byte value that terminates a line and releases the lock.
- `CNT_W`, default 16: width of the line counters.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: requester 0 byte valid.
- `req0_char` in 8: requester 0 byte.
- `req0_last` in 1: qualifies the final byte of requester 0's stream.
- `req0_ready` out 1: requester 0 byte accepted this cycle when high with `req0_valid`.
- `req1_valid`, `req1_char`, `req1_last`, `req1_ready`: same for requester 1.
- `sol_valid` out 1: byte valid to the solver.
- `sol_char` out 8: byte to the solver.
- `sol_ready` in 1: solver can accept a byte.
- `grant_id` out 1: current or most recent owner.
- `locked` out 1: a requester currently owns the solver.
- `done` out 1: both streams finished and their final lines forwarded; sticky until reset.
- `line_count` out CNT_W: total lines forwarded.
- `line_count0`, `line_count1` out CNT_W: per-requester line counts (see Configuration).

## Operation
- States: ARB, FWD.
- Reset values:
  - state ARB; `locked` 0; `grant_id` 0; round-robin pointer 0.
  - `fin0`/`fin1` 0; `done` 0; all counters 0.
  - All readies 0; `sol_valid` 0; `sol_char` 8'd0.
- ARB:
  - No transfer; both readies 0; `sol_valid` 0.
  - Eligible requester: `reqN_valid` high and `finN` clear.
  - Both eligible: the pointer's requester wins. One eligible: it wins regardless of pointer. None eligible: stay in ARB.
  - On a win: `grant_id` <= winner, `locked` <= 1, state <= FWD.
- FWD, combinational pass-through from owner X:
  - `sol_valid` = `reqX_valid`.
  - `sol_char` = `reqX_char`; `sol_char` = 0 when `sol_valid` is low.
  - `reqX_ready` = `sol_ready`.
  - Non-owner ready = 0.
- Transfer: a cycle with `reqX_valid` && `sol_ready` in FWD.
- Line end: a transfer where `reqX_char == LINE_TERM` or `reqX_last` is set. On line end:
  - State <= ARB, `locked` <= 0.
  - Pointer <= ~X.
  - `line_count` += 1.
- `reqX_last` on a transfer sets `finX`, even when the byte is not LINE_TERM; the lock is still released.
- Owner holding `valid` low mid-line: the lock is held indefinitely; no timeout.
- `done` <= 1 on the cycle after both `fin0` and `fin1` are set and state is ARB.
- Counters are CNT_W bits and wrap modulo 2^CNT_W with no saturation.
- A finished requester's later `valid` is ignored and its ready stays 0.

## Timing
- Arbitration costs exactly one bubble cycle per line. The first byte of a line can transfer at the earliest one cycle after ARB sees an eligible requester.
- Byte throughput inside a line is one per cycle while `valid` and `sol_ready` are both high. There is zero added latency: `sol_*` is combinational from the owner's inputs.
- `sol_valid` must not depend on `sol_ready`. The stall ready path is combinational, so it has no loop.
- Counters, `grant_id`, `locked`, `fin*` and `done` update on the clock edge following the qualifying transfer.
- Reset asserted mid-line: all state clears asynchronously and readies drop immediately. The partial line is not counted and resuming it is the system's problem.

## Configuration
- `SOL_LINE_ARB_STATS_EN` defined:
  - `line_count0`/`line_count1` count line ends per requester, with the same wrap rule as `line_count`.
  - Their sum mod 2^CNT_W always equals `line_count`.
- `SOL_LINE_ARB_STATS_EN` not defined: `line_count0`/`line_count1` are tied to 0 and their registers are not synthesised. All other behaviour is identical.

## Test plan
- Single source: req0 sends "ab\ncd\n" with `last` on the final byte, req1 idle, `sol_ready`=1.
  - Solver receives the 6 bytes in order, with one bubble cycle before "a" and before "c".
  - `line_count`=2; `done`=0 because req1 has not finished.
- Contention: both valid at reset release, req0 "x\n", req1 "y\n", both with `last`.
  - req0 is granted first (pointer 0), then req1.
  - Solver sees "x\ny\n"; `done`=1 two cycles after the final transfer.
- Round-robin fairness: both continuously valid with 1-byte lines "\n".
  - `grant_id` alternates 0,1,0,1 over four lines.
  - Transfers occur every other cycle.
- Backpressure: `sol_ready` is toggled 1,0,0,1 during a req1 line "123\n".
  - No byte is duplicated or dropped.
  - `req1_ready` mirrors `sol_ready` exactly; req0 is never granted mid-line even while req0 is valid.
- `last` without newline: req0 sends "7" with `last`=1.
  - The lock is released and `fin0` is set.
  - Later `req0_valid` gets no ready; `line_count` increments by 1.
- Reset mid-line: `rst_n` is pulsed low after 2 of 4 bytes.
  - All outputs return to reset values within the reset cycle.
  - Counters read 0; the next grant goes to requester 0.

Source files
------------

// File: rtl/sol_line_arbiter_if.sv
// Byte-stream bundle between two requesters, the line arbiter and the solver input port.
// master: arbiter side; slave: requesters plus solver side.
`default_nettype none

interface sol_line_arbiter_if;
  logic       req0_valid;
  logic [7:0] req0_char;
  logic       req0_last;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_char;
  logic       req1_last;
  logic       req1_ready;
  logic       sol_valid;
  logic [7:0] sol_char;
  logic       sol_ready;

  modport master (
    input  req0_valid, req0_char, req0_last,
    input  req1_valid, req1_char, req1_last,
    input  sol_ready,
    output req0_ready, req1_ready,
    output sol_valid, sol_char
  );

  modport slave (
    output req0_valid, req0_char, req0_last,
    output req1_valid, req1_char, req1_last,
    output sol_ready,
    input  req0_ready, req1_ready,
    input  sol_valid, sol_char
  );
endinterface

`default_nettype wire

// File: rtl/sol_line_arbiter.sv
// sol_line_arbiter: line-locked round-robin arbiter feeding one solver from two byte streams.
// Optional per-requester line counters: define SOL_LINE_ARB_STATS_EN.  Rev 1.0
`default_nettype none

module sol_line_arbiter #(
  parameter logic [7:0] LINE_TERM = 8'd10,
  parameter int         CNT_W     = 16
) (
  input  wire              clk,
  input  wire              rst_n,
  sol_line_arbiter_if.master bus,
  output logic             grant_id,
  output logic             locked,
  output logic             done,
  output logic [CNT_W-1:0] line_count,
  output logic [CNT_W-1:0] line_count0,
  output logic [CNT_W-1:0] line_count1
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ARB = 1'b0,
    FWD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             grant_q, grant_d;
  logic             ptr_q, ptr_d;
  logic [1:0]       fin_q, fin_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] line_count_q, line_count_d;

  logic             elig0, elig1;
  logic             own_valid, own_last;
  logic [7:0]       own_char;
  logic             line_end;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    fin_d        = fin_q;
    done_d       = done_q | (fin_q[0] & fin_q[1] & (state_q == ARB));
    line_count_d = line_count_q;
    line_end     = 1'b0;

    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.sol_valid  = 1'b0;
    bus.sol_char   = 8'd0;

    elig0     = bus.req0_valid & ~fin_q[0];
    elig1     = bus.req1_valid & ~fin_q[1];
    own_valid = grant_q ? bus.req1_valid : bus.req0_valid;
    own_char  = grant_q ? bus.req1_char  : bus.req0_char;
    own_last  = grant_q ? bus.req1_last  : bus.req0_last;

    case (state_q)
      ARB: begin
        if (elig0 || elig1) begin
          state_d = FWD;
          grant_d = (elig0 && elig1) ? ptr_q : elig1;
        end
      end
      FWD: begin
        // Ready follows sol_ready only, so sol_valid never depends on it.
        bus.sol_valid = own_valid;
        bus.sol_char  = own_valid ? own_char : 8'd0;
        if (grant_q) bus.req1_ready = bus.sol_ready;
        else         bus.req0_ready = bus.sol_ready;

        if (own_valid && bus.sol_ready && ((own_char == LINE_TERM) || own_last)) begin
          line_end     = 1'b1;
          state_d      = ARB;
          ptr_d        = ~grant_q;
          line_count_d = line_count_q + CNT_ONE;
          if (own_last) fin_d[grant_q] = 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB;
      grant_q      <= 1'b0;
      ptr_q        <= 1'b0;
      fin_q        <= 2'b00;
      done_q       <= 1'b0;
      line_count_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      ptr_q        <= ptr_d;
      fin_q        <= fin_d;
      done_q       <= done_d;
      line_count_q <= line_count_d;
    end
  end

  assign grant_id   = grant_q;
  assign locked     = (state_q == FWD);
  assign done       = done_q;
  assign line_count = line_count_q;

`ifdef SOL_LINE_ARB_STATS_EN
  logic [CNT_W-1:0] line_count0_q, line_count0_d;
  logic [CNT_W-1:0] line_count1_q, line_count1_d;

  always_comb begin
    line_count0_d = line_count0_q;
    line_count1_d = line_count1_q;
    if (line_end) begin
      if (grant_q) line_count1_d = line_count1_q + CNT_ONE;
      else         line_count0_d = line_count0_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_count0_q <= '0;
      line_count1_q <= '0;
    end else begin
      line_count0_q <= line_count0_d;
      line_count1_q <= line_count1_d;
    end
  end

  assign line_count0 = line_count0_q;
  assign line_count1 = line_count1_q;
`else
  assign line_count0 = '0;
  assign line_count1 = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sol_line_arbiter.sv
// Directed self-checking bench for sol_line_arbiter.
`default_nettype none

module tb_sol_line_arbiter;

`ifdef SOL_LINE_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        grant_id, locked, done;
  logic [15:0] line_count, line_count0, line_count1;

  sol_line_arbiter_if ifc ();

  sol_line_arbiter #(.LINE_TERM(8'd10), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (ifc),
    .grant_id    (grant_id),
    .locked      (locked),
    .done        (done),
    .line_count  (line_count),
    .line_count0 (line_count0),
    .line_count1 (line_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] rx[$];
  bit         en0, en1, last0_en, last1_en;

  logic       s_valid, s_grant, s_locked, s_r0, s_r1, s_done;
  logic [7:0] s_char;

  function automatic void push_str(input bit which, input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (which) q1.push_back(s[i]);
      else       q0.push_back(s[i]);
    end
  endfunction

  task automatic drive();
    ifc.req0_valid = en0 && (q0.size() > 0);
    ifc.req0_char  = (q0.size() > 0) ? q0[0] : 8'd0;
    ifc.req0_last  = last0_en && (q0.size() == 1);
    ifc.req1_valid = en1 && (q1.size() > 0);
    ifc.req1_char  = (q1.size() > 0) ? q1[0] : 8'd0;
    ifc.req1_last  = last1_en && (q1.size() == 1);
  endtask

  // One clock: drive, sample at negedge, pop accepted bytes after the edge.
  task automatic step();
    bit x0, x1;
    drive();
    @(negedge clk);
    s_valid  = ifc.sol_valid;
    s_char   = ifc.sol_char;
    s_grant  = grant_id;
    s_locked = locked;
    s_r0     = ifc.req0_ready;
    s_r1     = ifc.req1_ready;
    s_done   = done;
    x0 = ifc.req0_valid && ifc.req0_ready;
    x1 = ifc.req1_valid && ifc.req1_ready;
    if (ifc.sol_valid && ifc.sol_ready) rx.push_back(ifc.sol_char);
    @(posedge clk);
    #1;
    if (x0) void'(q0.pop_front());
    if (x1) void'(q1.pop_front());
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q0.delete(); q1.delete(); rx.delete();
    en0 = 1'b1; en1 = 1'b1; last0_en = 1'b0; last1_en = 1'b0;
    ifc.sol_ready = 1'b1;
    drive();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (ifc.sol_valid !== 1'b0) begin errors++; $display("FAIL rst_sol_valid got %b exp 0", ifc.sol_valid); end
    checks++; if (ifc.sol_char !== 8'd0) begin errors++; $display("FAIL rst_sol_char got %h exp 00", ifc.sol_char); end
    checks++; if ({ifc.req0_ready, ifc.req1_ready} !== 2'b00) begin errors++; $display("FAIL rst_readies got %b exp 00", {ifc.req0_ready, ifc.req1_ready}); end
    checks++; if ({grant_id, locked, done} !== 3'b000) begin errors++; $display("FAIL rst_status got %b exp 000", {grant_id, locked, done}); end
    checks++; if (line_count !== 16'd0) begin errors++; $display("FAIL rst_line_count got %0d exp 0", line_count); end
    checks++; if ({line_count0, line_count1} !== 32'd0) begin errors++; $display("FAIL rst_stats got %h exp 0", {line_count0, line_count1}); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_source();
    string      exp;
    bit   [7:0] vpat;
    exp  = "ab\ncd\n";
    vpat = 8'b1110_1110;
    do_reset();
    last0_en = 1'b1;
    push_str(1'b0, exp);
    for (int c = 0; c < 8; c++) begin
      step();
      checks++; if (s_valid !== vpat[c]) begin errors++; $display("FAIL single_valid_c%0d got %b exp %b", c, s_valid, vpat[c]); end
    end
    checks++; if (rx.size() != exp.len()) begin errors++; $display("FAIL single_rx_size got %0d exp %0d", rx.size(), exp.len()); end
    for (int i = 0; i < exp.len() && i < rx.size(); i++) begin
      checks++; if (rx[i] !== exp[i]) begin errors++; $display("FAIL single_rx_%0d got %h exp %h", i, rx[i], exp[i]); end
    end
    for (int c = 0; c < 3; c++) step();
    checks++; if (line_count !== 16'd2) begin errors++; $display("FAIL single_line_count got %0d exp 2", line_count); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done got %b exp 0", done); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL single_locked got %b exp 0", locked); end
  endtask

  task automatic test_contention();
    string      exp;
    bit   [5:0] vpat;
    bit   [5:0] gpat;
    exp  = "x\ny\n";
    vpat = 6'b11_0110;
    gpat = 6'b11_0000;
    do_reset();
    last0_en = 1'b1; last1_en = 1'b1;
    push_str(1'b0, "x\n");
    push_str(1'b1, "y\n");
    for (int c = 0; c < 8; c++) begin
      step();
      if (c < 6) begin
        checks++; if (s_valid !== vpat[c]) begin errors++; $display("FAIL cont_valid_c%0d got %b exp %b", c, s_valid, vpat[c]); end
        if (vpat[c]) begin
          checks++; if (s_grant !== gpat[c]) begin errors++; $display("FAIL cont_grant_c%0d got %b exp %b", c, s_grant, gpat[c]); end
        end
      end
      if (c >= 5) begin
        checks++; if (s_done !== (c == 7)) begin errors++; $display("FAIL cont_done_c%0d got %b exp %b", c, s_done, (c == 7)); end
      end
    end
    checks++; if (rx.size() != exp.len()) begin errors++; $display("FAIL cont_rx_size got %0d exp %0d", rx.size(), exp.len()); end
    for (int i = 0; i < exp.len() && i < rx.size(); i++) begin
      checks++; if (rx[i] !== exp[i]) begin errors++; $display("FAIL cont_rx_%0d got %h exp %h", i, rx[i], exp[i]); end
    end
    checks++; if (line_count !== 16'd2) begin errors++; $display("FAIL cont_line_count got %0d exp 2", line_count); end
    checks++; if (line_count0 !== (STATS ? 16'd1 : 16'd0)) begin errors++; $display("FAIL cont_lc0 got %0d exp %0d", line_count0, STATS ? 1 : 0); end
    checks++; if (line_count1 !== (STATS ? 16'd1 : 16'd0)) begin errors++; $display("FAIL cont_lc1 got %0d exp %0d", line_count1, STATS ? 1 : 0); end
  endtask

  task automatic test_fairness();
    bit [7:0] vpat;
    bit [7:0] gpat;
    vpat = 8'b1010_1010;
    gpat = 8'b1000_1000;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push_str(1'b0, "\n");
      push_str(1'b1, "\n");
    end
    for (int c = 0; c < 8; c++) begin
      step();
      checks++; if (s_valid !== vpat[c]) begin errors++; $display("FAIL rr_valid_c%0d got %b exp %b", c, s_valid, vpat[c]); end
      if (vpat[c]) begin
        checks++; if (s_grant !== gpat[c]) begin errors++; $display("FAIL rr_grant_c%0d got %b exp %b", c, s_grant, gpat[c]); end
      end
    end
    checks++; if (line_count !== 16'd4) begin errors++; $display("FAIL rr_line_count got %0d exp 4", line_count); end
    checks++; if (line_count0 !== (STATS ? 16'd2 : 16'd0)) begin errors++; $display("FAIL rr_lc0 got %0d exp %0d", line_count0, STATS ? 2 : 0); end
    checks++; if (line_count1 !== (STATS ? 16'd2 : 16'd0)) begin errors++; $display("FAIL rr_lc1 got %0d exp %0d", line_count1, STATS ? 2 : 0); end
  endtask

  task automatic test_backpressure();
    string      exp;
    bit   [6:0] rpat;
    exp  = "123\n";
    rpat = 7'b111_0011;
    do_reset();
    en0 = 1'b0;
    push_str(1'b0, "zz\n");
    push_str(1'b1, exp);
    for (int c = 0; c < 7; c++) begin
      ifc.sol_ready = rpat[c];
      step();
      en0 = 1'b1;
      if (c >= 1) begin
        checks++; if (s_r1 !== rpat[c]) begin errors++; $display("FAIL bp_r1_c%0d got %b exp %b", c, s_r1, rpat[c]); end
        checks++; if (s_r0 !== 1'b0) begin errors++; $display("FAIL bp_r0_c%0d got %b exp 0", c, s_r0); end
        checks++; if ({s_locked, s_grant} !== 2'b11) begin errors++; $display("FAIL bp_owner_c%0d got %b exp 11", c, {s_locked, s_grant}); end
        checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_c%0d got %b exp 1", c, s_valid); end
      end
    end
    checks++; if (rx.size() != exp.len()) begin errors++; $display("FAIL bp_rx_size got %0d exp %0d", rx.size(), exp.len()); end
    for (int i = 0; i < exp.len() && i < rx.size(); i++) begin
      checks++; if (rx[i] !== exp[i]) begin errors++; $display("FAIL bp_rx_%0d got %h exp %h", i, rx[i], exp[i]); end
    end
    ifc.sol_ready = 1'b1;
    step();
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL bp_bubble got %b exp 0", s_valid); end
    step();
    checks++; if ({s_grant, s_char} !== {1'b0, 8'h7a}) begin errors++; $display("FAIL bp_next_grant got %b/%h exp 0/7a", s_grant, s_char); end
  endtask

  task automatic test_last_no_newline();
    do_reset();
    last0_en = 1'b1;
    push_str(1'b0, "7");
    step();
    step();
    checks++; if ({s_valid, s_char} !== {1'b1, 8'h37}) begin errors++; $display("FAIL last_byte got %b/%h exp 1/37", s_valid, s_char); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL last_locked got %b exp 0", locked); end
    checks++; if (line_count !== 16'd1) begin errors++; $display("FAIL last_line_count got %0d exp 1", line_count); end
    push_str(1'b0, "8\n");
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if ({s_r0, s_valid, s_locked} !== 3'b000) begin errors++; $display("FAIL last_ignored_c%0d got %b exp 000", c, {s_r0, s_valid, s_locked}); end
    end
    checks++; if (line_count !== 16'd1) begin errors++; $display("FAIL last_line_count_hold got %0d exp 1", line_count); end
    checks++; if (rx.size() != 1) begin errors++; $display("FAIL last_rx_size got %0d exp 1", rx.size()); end
  endtask

  task automatic test_reset_mid_line();
    do_reset();
    push_str(1'b0, "q\n");
    push_str(1'b1, "abcd");
    for (int c = 0; c < 6; c++) step();
    checks++; if ({locked, grant_id} !== 2'b11) begin errors++; $display("FAIL mid_pre_owner got %b exp 11", {locked, grant_id}); end
    checks++; if (line_count !== 16'd1) begin errors++; $display("FAIL mid_pre_count got %0d exp 1", line_count); end
    rst_n = 1'b0;
    #1;
    checks++; if ({locked, grant_id, done} !== 3'b000) begin errors++; $display("FAIL mid_rst_status got %b exp 000", {locked, grant_id, done}); end
    checks++; if ({ifc.req0_ready, ifc.req1_ready, ifc.sol_valid} !== 3'b000) begin errors++; $display("FAIL mid_rst_hs got %b exp 000", {ifc.req0_ready, ifc.req1_ready, ifc.sol_valid}); end
    checks++; if (ifc.sol_char !== 8'd0) begin errors++; $display("FAIL mid_rst_char got %h exp 00", ifc.sol_char); end
    checks++; if ({line_count, line_count0, line_count1} !== 48'd0) begin errors++; $display("FAIL mid_rst_counts got %h exp 0", {line_count, line_count0, line_count1}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    rx.delete();
    push_str(1'b0, "m\n");
    step();
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL mid_post_bubble got %b exp 0", s_valid); end
    step();
    checks++; if ({s_valid, s_grant, s_char} !== {1'b1, 1'b0, 8'h6d}) begin errors++; $display("FAIL mid_post_grant got %b/%b/%h exp 1/0/6d", s_valid, s_grant, s_char); end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_single_source();
    test_contention();
    test_fairness();
    test_backpressure();
    test_last_no_newline();
    test_reset_mid_line();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
